// File: rtl/wrf_pkg.sv
// rtl/wrf_pkg.sv - shared word types, buffer entry layout and FSM states for the fabric sink
package wrf_pkg;

    localparam logic [1:0] c_WRF_DATA   = 2'd0;
    localparam logic [1:0] c_WRF_OOB    = 2'd1;
    localparam logic [1:0] c_WRF_STATUS = 2'd2;
    localparam logic [1:0] c_WRF_USER   = 2'd3;

    localparam int c_WRF_STATUS_ERR_BIT = 1;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  wtype;
        logic        last;
        logic        odd;
    } t_wrf_entry;

    localparam int c_WRF_ENTRY_W = $bits(t_wrf_entry);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_COMMIT,
        S_DROP
    } t_sink_state;

endpackage

// File: rtl/wrf_sink_ram.sv
// rtl/wrf_sink_ram.sv - simple dual-port frame RAM, one write port and one registered read port
module wrf_sink_ram #(
    parameter int g_words     = 2048,
    parameter int g_addr_bits = 11,
    parameter int g_width     = 20
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [g_addr_bits-1:0] waddr,
    input  logic [g_width-1:0]     wdata,
    input  logic                   re,
    input  logic [g_addr_bits-1:0] raddr,
    output logic [g_width-1:0]     rdata
);

    logic [g_width-1:0] mem [g_words];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wrf_sink_buffer.sv
// rtl/wrf_sink_buffer.sv - fabric sink with atomic frame commit/drop and FWFT read port
// Option macro: WRF_SINK_OOB_EN stores OOB beats (type=1) instead of discarding them.
module wrf_sink_buffer
    import wrf_pkg::*;
#(
    parameter int g_buf_words = 2048,
    parameter int g_addr_bits = 11
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [15:0] snk_dat_i,
    input  logic [1:0]  snk_sel_i,
    output logic        snk_stall_o,
    output logic        snk_ack_o,
    output logic        snk_err_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic [15:0] rd_dat_o,
    output logic [1:0]  rd_type_o,
    output logic        rd_last_o,
    output logic        rd_odd_o,
    output logic [31:0] frames_ok_o,
    output logic [31:0] frames_drop_o
);

`ifdef WRF_SINK_OOB_EN
    localparam logic c_OOB_EN = 1'b1;
`else
    localparam logic c_OOB_EN = 1'b0;
`endif

    localparam logic [g_addr_bits:0] c_ONE  = 1;
    localparam logic [g_addr_bits:0] c_FULL = {1'b1, {g_addr_bits{1'b0}}};

    t_sink_state            state, state_nxt;
    logic                   cyc_d;
    logic [g_addr_bits:0]   wp, cp, rp, wp_nxt, cp_nxt, wp_inc;
    logic                   hold_valid, hold_load, hold_clr;
    t_wrf_entry             hold_entry, ram_wdata, rd_q;
    logic                   ram_we, ram_re, out_valid, pop;
    logic                   ack_q, ok_inc, drop_inc;
    logic [31:0]            frames_ok, frames_drop;
    logic                   accept, cyc_rise, in_frame, store_beat, err_beat, overflow;

    assign snk_stall_o = rst_i || (state == S_COMMIT);
    assign accept      = snk_cyc_i && snk_stb_i && snk_we_i && !snk_stall_o;
    assign cyc_rise    = snk_cyc_i && !cyc_d;
    // The first beat may coincide with the cyc rising edge, so IDLE handles it as RECV would.
    assign in_frame    = (state == S_RECV) || ((state == S_IDLE) && cyc_rise);
    assign store_beat  = in_frame && accept &&
                         ((snk_adr_i == c_WRF_DATA) || (c_OOB_EN && (snk_adr_i == c_WRF_OOB)));
    assign err_beat    = in_frame && accept && (snk_adr_i == c_WRF_STATUS) &&
                         snk_dat_i[c_WRF_STATUS_ERR_BIT];
    assign wp_inc      = wp + c_ONE;
    assign overflow    = ((wp_inc - rp) == c_FULL);

    always_comb begin
        state_nxt = state;
        wp_nxt    = wp;
        cp_nxt    = cp;
        ram_we    = 1'b0;
        ram_wdata = hold_entry;
        hold_load = 1'b0;
        hold_clr  = 1'b0;
        ok_inc    = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cyc_rise) state_nxt = S_RECV;
            end
            S_RECV: begin
                if (!snk_cyc_i) state_nxt = hold_valid ? S_COMMIT : S_IDLE;
            end
            S_COMMIT: begin
                ram_we         = 1'b1;
                ram_wdata.last = 1'b1;
                wp_nxt         = wp_inc;
                cp_nxt         = wp_inc;
                hold_clr       = 1'b1;
                ok_inc         = 1'b1;
                state_nxt      = S_IDLE;
            end
            S_DROP: begin
                if (!snk_cyc_i) begin
                    wp_nxt    = cp;
                    hold_clr  = 1'b1;
                    drop_inc  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (err_beat) begin
            state_nxt = S_DROP;
        end else if (store_beat) begin
            if (hold_valid && overflow) begin
                state_nxt = S_DROP;
            end else begin
                // Spill the held word so the newest one stays back for the last flag.
                if (hold_valid) begin
                    ram_we = 1'b1;
                    wp_nxt = wp_inc;
                end
                hold_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cyc_d       <= 1'b1;
            wp          <= '0;
            cp          <= '0;
            hold_valid  <= 1'b0;
            hold_entry  <= '0;
            ack_q       <= 1'b0;
            frames_ok   <= '0;
            frames_drop <= '0;
        end else begin
            state <= state_nxt;
            cyc_d <= snk_cyc_i;
            wp    <= wp_nxt;
            cp    <= cp_nxt;
            ack_q <= accept;
            if (hold_load) begin
                hold_valid       <= 1'b1;
                hold_entry.data  <= snk_dat_i;
                hold_entry.wtype <= snk_adr_i;
                hold_entry.last  <= 1'b0;
                hold_entry.odd   <= (snk_sel_i == 2'b10);
            end else if (hold_clr) begin
                hold_valid <= 1'b0;
            end
            if (ok_inc)   frames_ok   <= frames_ok + 32'd1;
            if (drop_inc) frames_drop <= frames_drop + 32'd1;
        end
    end

    // The RAM output register acts as the prefetch stage; refill whenever it empties or pops.
    assign pop    = out_valid && rd_ready_i;
    assign ram_re = (rp != cp) && (!out_valid || pop);

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            rp        <= '0;
            out_valid <= 1'b0;
        end else begin
            if (ram_re) rp <= rp + c_ONE;
            if (ram_re) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    wrf_sink_ram #(
        .g_words     (g_buf_words),
        .g_addr_bits (g_addr_bits),
        .g_width     (c_WRF_ENTRY_W)
    ) u_ram (
        .clk   (clk_sys_i),
        .we    (ram_we),
        .waddr (wp[g_addr_bits-1:0]),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rp[g_addr_bits-1:0]),
        .rdata (rd_q)
    );

    assign snk_ack_o     = ack_q;
    assign snk_err_o     = 1'b0;
    assign rd_valid_o    = out_valid;
    assign rd_dat_o      = out_valid ? rd_q.data  : 16'h0000;
    assign rd_type_o     = out_valid ? rd_q.wtype : 2'b00;
    assign rd_last_o     = out_valid && rd_q.last;
    assign rd_odd_o      = out_valid && rd_q.odd;
    assign frames_ok_o   = frames_ok;
    assign frames_drop_o = frames_drop;

endmodule
